fifo_ctrl8x16: RTL and testbench



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram8x16.sv | 37 +++
 rtl/fifo_top8x16.sv | 63 ++++++
 rtl/fifo_ctrl8x16.sv | 111 +++++++++++
 tb/tb_fifo_ctrl8x16.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8x16 FIFO controller and its RAM wrapper.
//   RAM_WIDTH / RAM_DEPTH / ADDR_SIZE : geometry of the dual-port RAM
//   AF_THRESH / AE_THRESH             : default almost-full / almost-empty levels
//   addr_t / count_t / word_t         : address, occupancy and data types
//   op_e                              : accepted-operation encoding {push_ok, pop_ok}
package fifo_pkg;

    localparam int RAM_WIDTH = 16;
    localparam int RAM_DEPTH = 8;
    localparam int ADDR_SIZE = 3;
    localparam int AF_THRESH = 6;
    localparam int AE_THRESH = 1;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [ADDR_SIZE:0]   count_t;
    typedef logic [RAM_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/fifo_ram8x16.sv
// 8x16 dual-port RAM with independent write and read clocks and a registered
// data_out. clr clears the output register only; array contents are not reset.
// Ports:
//   wr_clk, we, wr_addr, data_in : write port
//   rd_clk, re, rd_addr, data_out : read port, data_out valid one edge after re
//   clr                           : synchronous active-high clear of data_out
module fifo_ram8x16 (
    input  logic        wr_clk,
    input  logic        rd_clk,
    input  logic        clr,
    input  logic        we,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] data_in,
    input  logic        re,
    input  logic [2:0]  rd_addr,
    output logic [15:0] data_out
);

    import fifo_pkg::*;

    word_t mem [RAM_DEPTH];

    always_ff @(posedge wr_clk) begin
        if (we) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (clr) begin
            data_out <= '0;
        end else if (re) begin
            data_out <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_top8x16.sv
// System-level wrapper: FIFO controller plus the 8x16 RAM, both RAM clocks
// tied to clk and the RAM clear tied to clr.
// Ports:
//   clk, clr          : clock and synchronous active-high reset
//   push, data_in     : producer side
//   pop, data_out     : consumer side, data_out valid when rd_valid is high
//   rd_valid, count, full, empty, almost_full, almost_empty, overflow, underflow
module fifo_top8x16 (
    input  logic        clk,
    input  logic        clr,
    input  logic        push,
    input  logic [15:0] data_in,
    input  logic        pop,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty,
    output logic        almost_full,
    output logic        almost_empty,
    output logic        overflow,
    output logic        underflow
);

    import fifo_pkg::*;

    logic  ram_we;
    logic  ram_re;
    addr_t ram_wr_addr;
    addr_t ram_rd_addr;

    fifo_ctrl8x16 u_ctrl (
        .clk          (clk),
        .clr          (clr),
        .push         (push),
        .pop          (pop),
        .ram_we       (ram_we),
        .ram_wr_addr  (ram_wr_addr),
        .ram_re       (ram_re),
        .ram_rd_addr  (ram_rd_addr),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    fifo_ram8x16 u_ram (
        .wr_clk   (clk),
        .rd_clk   (clk),
        .clr      (clr),
        .we       (ram_we),
        .wr_addr  (ram_wr_addr),
        .data_in  (data_in),
        .re       (ram_re),
        .rd_addr  (ram_rd_addr),
        .data_out (data_out)
    );

endmodule

// File: rtl/fifo_ctrl8x16.sv
// Single-clock FIFO controller driving the write and read ports of an
// 8x16 dual-port RAM. Tracks occupancy, produces registered occupancy flags,
// sticky overflow/underflow errors and a read-data-valid strobe aligned to the
// RAM's registered data_out.
// Ports:
//   clk          : clock, rising edge
//   clr          : synchronous active-high reset
//   push / pop   : producer write request / consumer read request
//   ram_we, ram_wr_addr : RAM write strobe and address (combinational)
//   ram_re, ram_rd_addr : RAM read strobe and address (combinational)
//   rd_valid     : RAM data_out holds the popped word this cycle
//   count        : occupancy, 0..RAM_DEPTH
//   full, empty, almost_full, almost_empty : registered occupancy flags
//   overflow, underflow : sticky error flags, cleared only by clr
module fifo_ctrl8x16 #(
    parameter int RAM_DEPTH = fifo_pkg::RAM_DEPTH,
    parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE,
    parameter int AF_THRESH = fifo_pkg::AF_THRESH,
    parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 push,
    input  logic                 pop,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_wr_addr,
    output logic                 ram_re,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    output logic                 rd_valid,
    output logic [ADDR_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    import fifo_pkg::*;

    localparam logic [ADDR_SIZE:0]   DEPTH_C   = (ADDR_SIZE+1)'(RAM_DEPTH);
    localparam logic [ADDR_SIZE:0]   AF_C      = (ADDR_SIZE+1)'(AF_THRESH);
    localparam logic [ADDR_SIZE:0]   AE_C      = (ADDR_SIZE+1)'(AE_THRESH);
    localparam logic [ADDR_SIZE:0]   CNT_ONE   = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE   = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   CNT_ZERO  = '0;

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE:0]   count_next;
    logic                 push_ok;
    logic                 pop_ok;
    op_e                  op;

    // Accept decisions use the registered flags from the start of the cycle;
    // clr suppresses both strobes so nothing reaches the RAM during reset.
    always_comb begin
        push_ok    = push & ~full  & ~clr;
        pop_ok     = pop  & ~empty & ~clr;
        op         = op_e'({push_ok, pop_ok});
        count_next = count;
        unique case (op)
            OP_PUSH: count_next = count + CNT_ONE;
            OP_POP:  count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    assign ram_we      = push_ok;
    assign ram_wr_addr = wr_ptr;
    assign ram_re      = pop_ok;
    assign ram_rd_addr = rd_ptr;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            // Pointers are exactly ADDR_SIZE wide, so 7 -> 0 wraps for free.
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count        <= count_next;
            // Flags come from the next count so they line up with count itself.
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == CNT_ZERO);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
            // RAM data_out is registered, so the popped word appears one edge later.
            rd_valid <= pop_ok;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl8x16.sv
module tb_fifo_ctrl8x16;

    logic        clk = 1'b0;
    logic        clr, push, pop;
    logic        ram_we, ram_re, rd_valid;
    logic [2:0]  ram_wr_addr, ram_rd_addr;
    logic [3:0]  count;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [15:0] din;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_ctrl8x16 dut (
        .clk          (clk),
        .clr          (clr),
        .push         (push),
        .pop          (pop),
        .ram_we       (ram_we),
        .ram_wr_addr  (ram_wr_addr),
        .ram_re       (ram_re),
        .ram_rd_addr  (ram_rd_addr),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // RAM stand-in: registered read, so popped words are observable with rd_valid.
    logic [15:0] mem [8];
    logic [15:0] dout;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= din;
        if (clr) dout <= 16'h0;
        else if (ram_re) dout <= mem[ram_rd_addr];
    end

    typedef struct {
        logic        clr, push, pop;
        logic [15:0] din;
        logic        we;
        logic [2:0]  wa;
        logic        re;
        logic [2:0]  ra;
        logic [3:0]  cnt;
        logic [5:0]  flg;   // {full, empty, almost_full, almost_empty, overflow, underflow}
        logic        rv;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] fl(input int c, input logic ovf, input logic unf);
        return {c == 8, c == 0, c >= 6, c <= 1, ovf, unf};
    endfunction

    function automatic vec_t mk(input logic c, input logic pu, input logic po, input logic [15:0] d,
                                input logic we, input int wa, input logic re, input int ra,
                                input int cnt, input logic ovf, input logic unf,
                                input logic rv, input logic [15:0] dv);
        vec_t v;
        v.clr = c; v.push = pu; v.pop = po; v.din = d;
        v.we = we; v.wa = 3'(wa); v.re = re; v.ra = 3'(ra);
        v.cnt = 4'(cnt); v.flg = fl(cnt, ovf, unf); v.rv = rv; v.dout = dv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        clr = v.clr; push = v.push; pop = v.pop; din = v.din;
        #1;
        chk($sformatf("v%0d ram_we", idx), 32'(ram_we), 32'(v.we));
        chk($sformatf("v%0d ram_re", idx), 32'(ram_re), 32'(v.re));
        if (v.we) chk($sformatf("v%0d ram_wr_addr", idx), 32'(ram_wr_addr), 32'(v.wa));
        if (v.re) chk($sformatf("v%0d ram_rd_addr", idx), 32'(ram_rd_addr), 32'(v.ra));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d count", idx), 32'(count), 32'(v.cnt));
        chk($sformatf("v%0d flags", idx),
            32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'(v.flg));
        chk($sformatf("v%0d rd_valid", idx), 32'(rd_valid), 32'(v.rv));
        if (v.rv) chk($sformatf("v%0d data_out", idx), 32'(dout), 32'(v.dout));
    endtask

    initial begin
        clr = 1'b1; push = 1'b0; pop = 1'b0; din = 16'h0;

        // reset with push held: no write strobe
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1,1,0,16'h0, 0,0,0,0, 0,0,0, 0,16'h0));
        // fill 8, then overflow attempt
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0,1,0,16'h1000+16'(i), 1,i,0,0, i+1,0,0, 0,16'h0));
        vecs.push_back(mk(0,1,0,16'h1008, 0,0,0,0, 8,1,0, 0,16'h0));
        // drain 8, then underflow attempt
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0,0,1,16'h0, 0,0,1,i, 7-i,1,0, 1,16'h1000+16'(i)));
        vecs.push_back(mk(0,0,1,16'h0, 0,0,0,0, 0,1,1, 0,16'h0));
        // clr clears sticky errors; then wrap: push 5, pop 5, push 6
        vecs.push_back(mk(1,0,0,16'h0, 0,0,0,0, 0,0,0, 0,16'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,16'h2000+16'(i), 1,i,0,0, i+1,0,0, 0,16'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,1,16'h0, 0,0,1,i, 4-i,0,0, 1,16'h2000+16'(i)));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,1,0,16'h3000+16'(i), 1,(5+i)%8,0,0, i+1,0,0, 0,16'h0));
        // pop 3 down to count 3, then simultaneous push+pop
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,16'h0, 0,0,1,5+i, 5-i,0,0, 1,16'h3000+16'(i)));
        vecs.push_back(mk(0,1,1,16'h4000, 1,3,1,0, 3,0,0, 1,16'h3003));
        // fill to 8, then push+pop at full
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,16'h4001+16'(i), 1,(4+i)%8,0,0, 4+i,0,0, 0,16'h0));
        vecs.push_back(mk(0,1,1,16'h4006, 0,0,1,1, 7,1,0, 1,16'h3004));
        // drain 7 to empty, then push+pop at empty
        vecs.push_back(mk(0,0,1,16'h0, 0,0,1,2, 6,1,0, 1,16'h3005));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,0,1,16'h0, 0,0,1,(3+i)%8, 5-i,1,0, 1,16'h4000+16'(i)));
        vecs.push_back(mk(0,1,1,16'h5000, 1,1,0,0, 1,1,1, 0,16'h0));

        #2;
        foreach (vecs[k]) run_vec(vecs[k], k);

        // Mid-operation clr: bring count to 4, pop once, then clr with pop held.
        for (int i = 0; i < 3; i++) begin
            clr = 0; push = 1; pop = 0; din = 16'h5001 + 16'(i);
            @(posedge clk); #1;
        end
        chk("mid count before pop", 32'(count), 32'd4);
        push = 0; pop = 1;
        #1;
        chk("mid pop ram_rd_addr", 32'(ram_rd_addr), 32'd1);
        @(posedge clk); #1;
        chk("mid pop rd_valid", 32'(rd_valid), 32'd1);
        chk("mid pop data_out", 32'(dout), 32'h5000);
        chk("mid pop count", 32'(count), 32'd3);
        clr = 1; pop = 1;
        #1;
        chk("clr ram_re forced", 32'(ram_re), 32'd0);
        @(posedge clk); #1;
        chk("clr count", 32'(count), 32'd0);
        chk("clr rd_valid dropped", 32'(rd_valid), 32'd0);
        chk("clr sticky", 32'({overflow, underflow}), 32'd0);
        chk("clr empty/ae", 32'({empty, almost_empty, full, almost_full}), 32'b1100);
        clr = 0; pop = 0; push = 1; din = 16'h6000;
        #1;
        chk("post-clr wr_ptr", 32'(ram_wr_addr), 32'd0);
        @(posedge clk); #1;
        push = 0; pop = 1;
        #1;
        chk("post-clr rd_ptr", 32'(ram_rd_addr), 32'd0);
        chk("post-clr ram_re", 32'(ram_re), 32'd1);
        @(posedge clk); #1;
        chk("post-clr data_out", 32'(dout), 32'h6000);
        chk("post-clr count", 32'(count), 32'd0);
        pop = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
